nw_traceback_aligner: RTL and testbench

Downstream consumer of the systolic Needleman-Wunsch grid's traceback. It accepts the stream of (x, y) cell coordinates the grid walks from (LENGTH-1, LENGTH-1) back to (0, 0), and classifies each step as diagonal, top or left. It emits one aligned character pair per step, with gap markers, through a small output FIFO with valid/ready handshake. It also recomputes the alignment score so it can be cross-checked against the grid.

---
 rtl/nw_traceback_aligner.sv | 203 ++++++++++++++++++++
 tb/tb_nw_traceback_aligner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nw_traceback_aligner.sv
// Consumes the Needleman-Wunsch traceback coordinate stream, emits aligned character
// pairs (with gap markers) through a small FIFO and recomputes the alignment score.
module nw_traceback_aligner #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int SWIDTH      = 16,
  parameter int CORD_LENGTH = 8,
  parameter int DEPTH       = 4,
  parameter int MATCH       = 1,
  parameter int MISMATCH    = -1,
  parameter int INDEL       = -1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CORD_LENGTH-1:0]   in_x,
  input  logic [CORD_LENGTH-1:0]   in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CWIDTH-1:0]        out_c1,
  output logic [CWIDTH-1:0]        out_c2,
  output logic                     out_gap1,
  output logic                     out_gap2,
  output logic                     out_last,
  output logic [SWIDTH-1:0]        score,
  output logic                     done,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CORD_LENGTH-1:0] LastIdx = CORD_LENGTH'(LENGTH - 1);
  localparam logic [CORD_LENGTH-1:0] One     = CORD_LENGTH'(1);

  typedef enum logic [2:0] {StIdle, StRun, StFlush, StDone, StErr} state_e;

  typedef struct packed {
    logic [CWIDTH-1:0] c1;
    logic [CWIDTH-1:0] c2;
    logic              gap1;
    logic              gap2;
    logic              last;
  } pair_t;

  state_e                   state_q;
  logic [CORD_LENGTH-1:0]   prev_x_q, prev_y_q;
  logic signed [SWIDTH-1:0] score_q;
  logic                     done_q, error_q;

  pair_t                    mem_q [DEPTH];
  logic [AW-1:0]            wr_q, rd_q;
  logic [AW:0]              count_q;

  logic                     full, accept, push, pop;
  logic [CORD_LENGTH-1:0]   dx, dy;
  logic [CWIDTH-1:0]        ch1, ch2;
  logic                     step_diag, step_top, step_left, step_ok, gap_step, cur_origin;
  pair_t                    push_data;
  logic signed [SWIDTH-1:0] delta;

  // Constant-index mux keeps the lookup free of variable part-selects.
  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                input logic [CORD_LENGTH-1:0]   idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (idx == CORD_LENGTH'(i)) c = str[(LENGTH-1-i)*CWIDTH +: CWIDTH];
    end
    return c;
  endfunction

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    unique case (state_q)
      StIdle, StRun: in_ready = ~full;
      StErr:         in_ready = 1'b1;
      default:       in_ready = 1'b0;
    endcase
  end

  always_comb begin
    dx         = prev_x_q - in_x;
    dy         = prev_y_q - in_y;
    ch1        = char_at(s1, prev_y_q);
    ch2        = char_at(s2, prev_x_q);
    step_diag  = (dx == One) && (dy == One);
    step_top   = (dx == '0) && (dy == One);
    step_left  = (dx == One) && (dy == '0);
    step_ok    = step_diag | step_top | step_left;
    cur_origin = (in_x == '0) && (in_y == '0);
    gap_step   = (state_q == StRun) && (step_top | step_left);
    push       = ((state_q == StRun) && accept && step_ok) || ((state_q == StFlush) && !full);

    // The flush pair is a diagonal on (0,0), which prev already holds.
    push_data.c1   = ch1;
    push_data.c2   = ch2;
    push_data.gap1 = 1'b0;
    push_data.gap2 = 1'b0;
    push_data.last = (state_q == StFlush);
    if (state_q == StRun && step_top) begin
      push_data.c2   = '0;
      push_data.gap2 = 1'b1;
    end
    if (state_q == StRun && step_left) begin
      push_data.c1   = '0;
      push_data.gap1 = 1'b1;
    end

    delta = (ch1 == ch2) ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
    if (gap_step) delta = SWIDTH'(INDEL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      prev_x_q <= '0;
      prev_y_q <= '0;
      score_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_x == LastIdx && in_y == LastIdx) begin
              prev_x_q <= in_x;
              prev_y_q <= in_y;
              state_q  <= (LENGTH == 1) ? StFlush : StRun;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (step_ok) begin
              score_q  <= score_q + delta;
              prev_x_q <= in_x;
              prev_y_q <= in_y;
              if (cur_origin) state_q <= StFlush;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
        end
        StFlush: begin
          if (!full) begin
            score_q <= score_q + delta;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone, StErr: state_q <= state_q;
        default:       state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  // Head fields read as zero whenever the FIFO is empty.
  always_comb begin
    out_c1   = '0;
    out_c2   = '0;
    out_gap1 = 1'b0;
    out_gap2 = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      out_c1   = mem_q[rd_q].c1;
      out_c2   = mem_q[rd_q].c2;
      out_gap1 = mem_q[rd_q].gap1;
      out_gap2 = mem_q[rd_q].gap2;
      out_last = mem_q[rd_q].last;
    end
  end

  assign score = score_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_nw_traceback_aligner.sv
// Directed bench for nw_traceback_aligner: table-driven traceback streams plus
// backpressure, protocol-error and mid-run reset sequences.
module tb_nw_traceback_aligner;

  localparam int L  = 4;
  localparam int CW = 2;
  localparam int SW = 16;
  localparam int CL = 8;
  localparam int D  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [L*CW-1:0] s1, s2;
  logic            in_valid, in_ready;
  logic [CL-1:0]   in_x, in_y;
  logic            out_valid, out_ready;
  logic [CW-1:0]   out_c1, out_c2;
  logic            out_gap1, out_gap2, out_last;
  logic [SW-1:0]   score;
  logic            done, error;

  nw_traceback_aligner #(
    .LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL), .DEPTH(D),
    .MATCH(1), .MISMATCH(-1), .INDEL(-1)
  ) dut (
    .clk(clk), .reset(reset), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
    .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last),
    .score(score), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    logic          g1;
    logic          g2;
    logic          last;
  } pair_t;

  // One coordinate and the score expected right after it is accepted.
  typedef struct {
    int x;
    int y;
    int sc;
  } vec_t;

  pair_t got[$];
  int    checks   = 0;
  int    failures = 0;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      got.push_back({out_c1, out_c2, out_gap1, out_gap2, out_last});
  end

  function automatic pair_t mk(int c1, int c2, bit g1, bit g2, bit last);
    pair_t p;
    p.c1 = CW'(c1); p.c2 = CW'(c2); p.g1 = g1; p.g2 = g2; p.last = last;
    return p;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    got.delete();
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic push_coord(input int x, input int y);
    int n;
    in_x     = CL'(x);
    in_y     = CL'(y);
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      failures++;
      checks++;
      $display("FAIL accept_timeout: coord (%0d,%0d) never accepted", x, y);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_asserted", longint'(done), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_pairs(input string name, input pair_t exp[$]);
    check({name, "_pair_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_pair%0d", name, i), got[i], exp[i]);
    end
  endtask

  task automatic run_stream(input string name, input vec_t v[$], input pair_t p[$],
                            input int final_sc);
    foreach (v[i]) begin
      push_coord(v[i].x, v[i].y);
      check($sformatf("%s_score_step%0d", name, i), longint'($signed(score)), v[i].sc);
    end
    wait_done();
    check({name, "_final_score"}, longint'($signed(score)), final_sc);
    check({name, "_error"}, longint'(error), 0);
    check_pairs(name, p);
  endtask

  vec_t  v_diag[$];
  vec_t  v_gap[$];
  pair_t p_diag[$];
  pair_t p_gap[$];

  initial begin
    // s[i] == i for both strings.
    v_diag = '{'{3, 3, 0}, '{2, 2, 1}, '{1, 1, 2}, '{0, 0, 3}};
    p_diag = '{mk(3, 3, 0, 0, 0), mk(2, 2, 0, 0, 0), mk(1, 1, 0, 0, 0), mk(0, 0, 0, 0, 1)};
    v_gap  = '{'{3, 3, 0}, '{3, 2, -1}, '{2, 1, -2}, '{1, 0, -3}, '{0, 0, -4}};
    p_gap  = '{mk(3, 0, 0, 1, 0), mk(2, 3, 0, 0, 0), mk(1, 2, 0, 0, 0),
               mk(0, 1, 1, 0, 0), mk(0, 0, 0, 0, 1)};

    s1 = 8'b00_01_10_11;
    s2 = 8'b00_01_10_11;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b1;

    do_reset();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_score", longint'(score), 0);
    check("rst_done", longint'(done), 0);
    check("rst_error", longint'(error), 0);
    check("rst_head", longint'({out_c1, out_c2, out_gap1, out_gap2, out_last}), 0);

    run_stream("diag", v_diag, p_diag, 4);
    check("diag_done_in_ready", longint'(in_ready), 0);

    do_reset();
    run_stream("gap", v_gap, p_gap, -3);

    // Backpressure: two pushes fill the FIFO and in_ready must drop.
    do_reset();
    out_ready = 1'b0;
    push_coord(3, 3);
    push_coord(2, 2);
    push_coord(1, 1);
    in_x = '0;
    in_y = '0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_in_ready_low", longint'(in_ready), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    check("bp_head_stable", longint'({out_c1, out_c2, out_gap1, out_gap2, out_last}),
          longint'(mk(3, 3, 0, 0, 0)));
    check("bp_score", longint'($signed(score)), 2);
    out_ready = 1'b1;
    push_coord(0, 0);
    wait_done();
    check("bp_final_score", longint'($signed(score)), 4);
    check_pairs("bp", p_diag);

    // Illegal step after a valid start.
    do_reset();
    push_coord(3, 3);
    push_coord(1, 1);
    check("err_step_error", longint'(error), 1);
    check("err_step_done", longint'(done), 0);
    check("err_step_in_ready", longint'(in_ready), 1);
    push_coord(2, 2);
    repeat (2) @(posedge clk);
    #1;
    check("err_step_error_sticky", longint'(error), 1);
    check("err_step_out_valid", longint'(out_valid), 0);
    check("err_step_pairs", got.size(), 0);
    check("err_step_score", longint'(score), 0);

    // Wrong first coordinate.
    do_reset();
    push_coord(2, 3);
    check("err_first_error", longint'(error), 1);
    check("err_first_out_valid", longint'(out_valid), 0);

    // Reset mid-operation, then a clean stream.
    do_reset();
    out_ready = 1'b0;
    push_coord(3, 3);
    push_coord(2, 2);
    check("mid_out_valid_before", longint'(out_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_out_valid", longint'(out_valid), 0);
    check("mid_score", longint'(score), 0);
    check("mid_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    got.delete();
    run_stream("mid", v_diag, p_diag, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
